// File: rtl/ext_pkg.sv
// ext_pkg: shared extension-mode constants and occupancy state type
package ext_pkg;
  typedef logic [2:0] ext_mode_t;
  localparam ext_mode_t EXT_ZERO     = 3'd0;
  localparam ext_mode_t EXT_SIGN     = 3'd1;
  localparam ext_mode_t EXT_UPPER    = 3'd2;
  localparam ext_mode_t EXT_SIGN_SL2 = 3'd3;
  localparam ext_mode_t EXT_ZERO_SL2 = 3'd4;
  typedef enum logic [1:0] {OCC_EMPTY, OCC_ONE, OCC_FULL} occ_t;
endpackage

// File: rtl/ext_core.sv
// ext_core: combinational immediate extender; unused modes yield zero
module ext_core import ext_pkg::*; #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  imm,
  input  ext_mode_t        mode,
  output logic [OUT_W-1:0] result
);
  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;
  // select the extension; shifts drop bits past the top of the result
  always_comb begin
    zext   = {{(OUT_W-IN_W){1'b0}}, imm};
    sext   = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    result = mode == EXT_ZERO     ? zext :
             mode == EXT_SIGN     ? sext :
             mode == EXT_UPPER    ? {imm, {(OUT_W-IN_W){1'b0}}} :
             mode == EXT_SIGN_SL2 ? sext << 2 :
             mode == EXT_ZERO_SL2 ? zext << 2 : '0;
  end
endmodule

// File: rtl/ext_pipe.sv
// ext_pipe: registered immediate extension with 2-entry skid buffer and flush
module ext_pipe import ext_pkg::*; #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_imm,
  input  logic [2:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [TAG_W-1:0] out_tag
);
  occ_t             state_q, state_d;
  logic [OUT_W-1:0] m_data_q, m_data_d, s_data_q, s_data_d, ext_data;
  logic [TAG_W-1:0] m_tag_q, m_tag_d, s_tag_q, s_tag_d;
  logic             accept, drain;

  ext_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
    .imm    (in_imm),
    .mode   (ext_mode_t'(in_mode)),
    .result (ext_data)
  );

  assign in_ready  = state_q != OCC_FULL;
  assign out_valid = state_q != OCC_EMPTY;
  assign out_data  = m_data_q;
  assign out_tag   = m_tag_q;
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // occupancy transitions; S only fills while M is stalled, and flush overrides all
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    m_tag_d  = m_tag_q;
    s_data_d = s_data_q;
    s_tag_d  = s_tag_q;
    case (state_q)
      OCC_EMPTY: if (accept) begin
        state_d  = OCC_ONE;
        m_data_d = ext_data;
        m_tag_d  = in_tag;
      end
      OCC_ONE: if (accept && drain) begin
        m_data_d = ext_data;
        m_tag_d  = in_tag;
      end else if (accept) begin
        state_d  = OCC_FULL;
        s_data_d = ext_data;
        s_tag_d  = in_tag;
      end else if (drain) begin
        state_d  = OCC_EMPTY;
      end
      OCC_FULL: if (drain) begin
        state_d  = OCC_ONE;
        m_data_d = s_data_q;
        m_tag_d  = s_tag_q;
      end
      default: state_d = OCC_EMPTY;
    endcase
    if (flush) state_d = OCC_EMPTY;
  end

  // state and payload registers; payload is left untouched by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= OCC_EMPTY;
      m_data_q <= '0;
      m_tag_q  <= '0;
      s_data_q <= '0;
      s_tag_q  <= '0;
    end else begin
      state_q  <= state_d;
      m_data_q <= m_data_d;
      m_tag_q  <= m_tag_d;
      s_data_q <= s_data_d;
      s_tag_q  <= s_tag_d;
    end
  end
endmodule

// File: tb/tb_ext_pipe.sv
// tb_ext_pipe: randomized scoreboard bench for ext_pipe
module tb_ext_pipe;
  logic        clk = 0, rst_n = 0, flush = 0;
  logic        in_valid = 0, in_ready, out_valid, out_ready = 0;
  logic [15:0] in_imm = 0;
  logic [2:0]  in_mode = 0;
  logic [4:0]  in_tag = 0, out_tag;
  logic [31:0] out_data;
  logic        v_in_valid = 0, v_in_ready, v_out_valid;
  logic [11:0] v_in_imm = 0;
  logic [2:0]  v_in_mode = 0;
  logic [4:0]  v_in_tag = 0, v_out_tag;
  logic [23:0] v_out_data;
  int checks = 0, errors = 0;

  typedef struct {logic [31:0] d; logic [4:0] t;} beat_t;
  beat_t q[$];
  logic [4:0] drained[$];
  logic hold_valid = 0;
  logic [31:0] hold_data;
  logic [4:0] hold_tag;

  always #5 clk = ~clk;

  ext_pipe dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_imm(in_imm), .in_mode(in_mode), .in_tag(in_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  ext_pipe #(.IN_W(12), .OUT_W(24)) dut_v (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(v_in_valid), .in_ready(v_in_ready),
    .in_imm(v_in_imm), .in_mode(v_in_mode), .in_tag(v_in_tag), .out_valid(v_out_valid),
    .out_ready(1'b1), .out_data(v_out_data), .out_tag(v_out_tag)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_ext(input logic [15:0] imm, input logic [2:0] mode);
    longint z, s, r;
    z = longint'(imm);
    s = imm >= 16'h8000 ? z - 65536 : z;
    case (mode)
      3'd0: r = z;
      3'd1: r = s;
      3'd2: r = z * 65536;
      3'd3: r = s * 4;
      3'd4: r = z * 4;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic step(input logic v, input logic [15:0] imm, input logic [2:0] mode,
                      input logic [4:0] tag, input logic ordy, input logic fl, output logic acc);
    beat_t b;
    logic rdy, mv;
    @(negedge clk);
    in_valid = v; in_imm = imm; in_mode = mode; in_tag = tag; out_ready = ordy; flush = fl;
    #1;
    rdy = q.size() < 2;
    mv  = q.size() > 0;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, mv);
    if (hold_valid) begin
      chk("stall_data", out_data, hold_data);
      chk("stall_tag", out_tag, hold_tag);
    end
    hold_valid = 0;
    if (mv && !fl) begin
      if (ordy) begin
        b = q.pop_front();
        chk("out_data", out_data, b.d);
        chk("out_tag", out_tag, b.t);
        drained.push_back(out_tag);
      end else begin
        hold_valid = 1; hold_data = out_data; hold_tag = out_tag;
      end
    end
    acc = v && rdy && !fl;
    if (acc) q.push_back('{ref_ext(imm, mode), tag});
    if (fl) q.delete();
  endtask

  initial begin
    logic acc;
    logic [2:0]  modes[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
    logic [31:0] exps[6]  = '{32'h00008001, 32'hFFFF8001, 32'h80010000,
                              32'hFFFE0004, 32'h00020004, 32'h0};
    int n;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1 rst_n = 1;

    for (int i = 0; i < 6; i++) begin
      step(1, 16'h8001, modes[i], 5'(i + 1), 1, 0, acc);
      @(posedge clk); #1;
      chk("sweep_valid", out_valid, 1);
      chk("sweep_data", out_data, exps[i]);
      chk("sweep_tag", out_tag, 32'(i + 1));
    end
    step(0, 0, 0, 0, 1, 0, acc);

    @(negedge clk); v_in_valid = 1; v_in_mode = 3'd1; v_in_imm = 12'hFFF;
    @(posedge clk); #1 chk("var_sign", v_out_data, 24'hFFFFFF);
    @(negedge clk); v_in_mode = 3'd2;
    @(posedge clk); #1 chk("var_upper", v_out_data, 24'hFFF000);
    @(negedge clk); v_in_valid = 0;

    drained.delete();
    step(1, 16'h0011, 0, 1, 0, 0, acc);
    step(1, 16'h0022, 1, 2, 0, 0, acc);
    @(posedge clk); #1 chk("bp_in_ready_low", in_ready, 0);
    step(1, 16'h0033, 4, 3, 0, 0, acc);
    chk("bp_tag3_held_off", acc, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 16'h0033, 4, 3, 1, 0, acc);
      if (acc) break;
    end
    chk("bp_tag3_accepted", acc, 1);
    for (int i = 0; i < 10 && q.size() > 0; i++) step(0, 0, 0, 0, 1, 0, acc);
    step(0, 0, 0, 0, 1, 0, acc);
    chk("bp_count", drained.size(), 3);
    for (int i = 0; i < drained.size() && i < 3; i++) chk("bp_order", drained[i], 32'(i + 1));

    n = 0;
    for (int c = 0; c < 3000 && n < 100; c++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom), 5'($urandom),
           1'($urandom_range(0, 1)), 0, acc);
      if (acc) n++;
    end
    chk("stream_beats", n, 100);
    for (int i = 0; i < 10 && q.size() > 0; i++) step(0, 0, 0, 0, 1, 0, acc);
    chk("stream_empty", q.size(), 0);

    step(1, 16'h1234, 0, 9, 0, 0, acc);
    step(1, 16'h5678, 0, 10, 0, 0, acc);
    step(1, 16'h9ABC, 0, 11, 0, 1, acc);
    @(posedge clk); #1;
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    drained.delete();
    step(1, 16'h0007, 3, 12, 1, 0, acc);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 0, acc);
    chk("flush_count", drained.size(), 1);

    step(1, 16'hAAAA, 0, 13, 0, 0, acc);
    step(1, 16'hBBBB, 0, 14, 0, 0, acc);
    @(negedge clk); in_valid = 0;
    #2 rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_in_ready", in_ready, 1);
    q.delete(); hold_valid = 0;
    @(posedge clk); #1 rst_n = 1;
    step(1, 16'hFFFF, 1, 15, 1, 0, acc);
    @(posedge clk); #1;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_data", out_data, 32'hFFFFFFFF);
    chk("post_rst_tag", out_tag, 15);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 0, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
